// File: rtl/v_filter_pkg.sv
// Shared definitions for the video filter controller: mode encoding, mode sequencing
// and vsync polarity normalisation.
package v_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_SPLIT  = 2'd1,
    MODE_FULL   = 2'd2,
    MODE_SWEEP  = 2'd3
  } mode_t;

  localparam int MODE_COUNT = 4;

  function automatic mode_t mode_next(input mode_t m);
    mode_t r;
    if (m == mode_t'(MODE_COUNT - 1)) begin
      r = MODE_BYPASS;
    end else begin
      r = mode_t'(m + 2'd1);
    end
    return r;
  endfunction

  // Returns 1 when vsync sits at its active level, whatever the board polarity.
  function automatic logic vs_active(input logic vs, input logic act_high);
    return act_high ? vs : ~vs;
  endfunction

endpackage

// File: rtl/v_filter_ctrl_if.sv
// Board-side I/O bundle of the filter controller: button, vsync in; mode/filter controls out.
interface v_filter_ctrl_if #(
  parameter int X_WIDTH = 11
);
  logic               btn_n;
  logic               vsync;
  logic [1:0]         mode;
  logic               posterize_en;
  logic               split_en;
  logic [X_WIDTH-1:0] split_x;
  logic               frame_tick;

  modport master (
    output btn_n, vsync,
    input  mode, posterize_en, split_en, split_x, frame_tick
  );

  modport slave (
    input  btn_n, vsync,
    output mode, posterize_en, split_en, split_x, frame_tick
  );
endinterface

// File: rtl/v_filter_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, one-cycle press pulse
// on the debounced released->pressed transition.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic i_pclk,
  input  logic i_arst,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int              CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_settled;

  assign w_differs = r_sync2 ^ r_level;
  assign w_settled = w_differs & (r_cnt == CNT_LAST);

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= w_settled & r_level;
      if (w_settled) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differs) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/v_filter_ctrl.sv
// Frame-synchronous mode controller for the posterize filter: button presses queue one
// mode advance, applied together with all output updates only at frame start.
module v_filter_ctrl #(
  parameter int VS_ACTIVE_HIGH = 0,
  parameter int X_WIDTH        = 11,
  parameter int X_ACTIVE       = 1280,
  parameter int SPLIT_DEFAULT  = 640,
  parameter int SWEEP_STEP     = 8,
  parameter int DEB_CYCLES     = 1000000
) (
  input logic            i_pclk,
  input logic            i_arst,
  v_filter_ctrl_if.slave bus
);
  import v_filter_pkg::*;

  localparam logic [X_WIDTH:0]   XMAX_EXT    = (X_WIDTH + 1)'(X_ACTIVE);
  localparam logic [X_WIDTH:0]   STEP_EXT    = (X_WIDTH + 1)'(SWEEP_STEP);
  localparam logic [X_WIDTH-1:0] XMAX_X      = X_WIDTH'(X_ACTIVE);
  localparam logic [X_WIDTH-1:0] STEP_X      = X_WIDTH'(SWEEP_STEP);
  localparam logic [X_WIDTH-1:0] SPLIT_DEF_X = X_WIDTH'(SPLIT_DEFAULT);

  logic               w_press;
  logic               w_vs_act;
  logic               r_vs_prev;
  logic               r_tick;
  mode_t              r_mode;
  mode_t              w_mode_nxt;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               r_en;
  logic               w_en_nxt;
  logic               r_split_en;
  logic               w_split_en_nxt;
  logic [X_WIDTH-1:0] r_split_x;
  logic [X_WIDTH-1:0] w_split_x_nxt;
  logic               r_dir_down;
  logic               w_dir_down_nxt;
  logic [X_WIDTH:0]   w_x_up;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .i_pclk  (i_pclk),
    .i_arst  (i_arst),
    .i_btn_n (bus.btn_n),
    .o_press (w_press)
  );

  assign w_vs_act = vs_active(bus.vsync, VS_ACTIVE_HIGH != 0);

  // History resets to "active" so a vsync already active at reset release is not a frame start.
  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_vs_prev <= w_vs_act;
      r_tick    <= w_vs_act & ~r_vs_prev;
    end
  end

  assign w_x_up = {1'b0, r_split_x} + STEP_EXT;

  always_comb begin
    w_mode_nxt     = r_mode;
    w_pending_nxt  = r_pending;
    w_en_nxt       = r_en;
    w_split_en_nxt = r_split_en;
    w_split_x_nxt  = r_split_x;
    w_dir_down_nxt = r_dir_down;
    if (r_tick) begin
      // A press landing in the tick cycle itself is consumed by this tick.
      if (r_pending | w_press) begin
        w_mode_nxt = mode_next(r_mode);
      end else begin
        w_mode_nxt = r_mode;
      end
      w_pending_nxt = 1'b0;
      case (w_mode_nxt)
        MODE_BYPASS: begin
          w_en_nxt       = 1'b0;
          w_split_en_nxt = 1'b0;
          w_split_x_nxt  = '0;
          w_dir_down_nxt = 1'b0;
        end
        MODE_SPLIT: begin
          w_en_nxt       = 1'b1;
          w_split_en_nxt = 1'b1;
          w_split_x_nxt  = SPLIT_DEF_X;
          w_dir_down_nxt = 1'b0;
        end
        MODE_FULL: begin
          w_en_nxt       = 1'b1;
          w_split_en_nxt = 1'b0;
          w_split_x_nxt  = '0;
          w_dir_down_nxt = 1'b0;
        end
        MODE_SWEEP: begin
          w_en_nxt       = 1'b1;
          w_split_en_nxt = 1'b1;
          if (r_mode != MODE_SWEEP) begin
            w_split_x_nxt  = '0;
            w_dir_down_nxt = 1'b0;
          end else if (!r_dir_down) begin
            if (w_x_up >= XMAX_EXT) begin
              w_split_x_nxt  = XMAX_X;
              w_dir_down_nxt = 1'b1;
            end else begin
              w_split_x_nxt  = w_x_up[X_WIDTH-1:0];
              w_dir_down_nxt = 1'b0;
            end
          end else begin
            if ({1'b0, r_split_x} <= STEP_EXT) begin
              w_split_x_nxt  = '0;
              w_dir_down_nxt = 1'b0;
            end else begin
              w_split_x_nxt  = r_split_x - STEP_X;
              w_dir_down_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_en_nxt       = 1'b0;
          w_split_en_nxt = 1'b0;
          w_split_x_nxt  = '0;
          w_dir_down_nxt = 1'b0;
        end
      endcase
    end else begin
      if (w_press) begin
        w_pending_nxt = 1'b1;
      end else begin
        w_pending_nxt = r_pending;
      end
    end
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      r_mode     <= MODE_BYPASS;
      r_pending  <= 1'b0;
      r_en       <= 1'b0;
      r_split_en <= 1'b0;
      r_split_x  <= '0;
      r_dir_down <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_pending  <= w_pending_nxt;
      r_en       <= w_en_nxt;
      r_split_en <= w_split_en_nxt;
      r_split_x  <= w_split_x_nxt;
      r_dir_down <= w_dir_down_nxt;
    end
  end

  assign bus.mode         = r_mode;
  assign bus.posterize_en = r_en;
  assign bus.split_en     = r_split_en;
  assign bus.split_x      = r_split_x;
  assign bus.frame_tick   = r_tick;
endmodule

// File: tb/tb_v_filter_ctrl.sv
// Self-checking bench for v_filter_ctrl: frame-level reference model driven by press
// landing times and vsync history, plus fixed expectations for the key scenarios.
module tb_v_filter_ctrl;
  localparam int XW     = 11;
  localparam int DEB    = 16;
  localparam int XA     = 64;
  localparam int STEP   = 24;
  localparam int SPLITD = 32;
  localparam int LAT    = DEB + 2;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  v_filter_ctrl_if #(.X_WIDTH(XW)) bus();

  v_filter_ctrl #(
    .VS_ACTIVE_HIGH (0),
    .X_WIDTH        (XW),
    .X_ACTIVE       (XA),
    .SPLIT_DEFAULT  (SPLITD),
    .SWEEP_STEP     (STEP),
    .DEB_CYCLES     (DEB)
  ) dut (
    .i_pclk (clk),
    .i_arst (arst),
    .bus    (bus)
  );

  typedef struct {
    int at;
    int bounce;
    int hold;
  } press_t;

  press_t      plans[$];
  int          lands[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          m_mode;
  int          m_x;
  bit          m_up;
  logic        vs_d1, vs_d2, cur_vs;
  logic        exp_tick;
  logic [15:0] obs, expv;

  function automatic logic [15:0] model_vec(input logic t);
    int   x;
    logic en, se;
    en = (m_mode != 0);
    se = (m_mode == 1) || (m_mode == 3);
    x  = (m_mode == 1) ? SPLITD : ((m_mode == 3) ? m_x : 0);
    return {t, m_mode[1:0], en, se, x[XW-1:0]};
  endfunction

  // At a frame start: any press landed since the previous start advances the mode once.
  task automatic model_tick();
    bit adv = 1'b0;
    while (lands.size() > 0 && lands[0] <= cyc) begin
      void'(lands.pop_front());
      adv = 1'b1;
    end
    if (adv) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 3) begin
        m_x  = 0;
        m_up = 1'b1;
      end
    end else if (m_mode == 3) begin
      if (m_up) begin
        if (m_x + STEP >= XA) begin m_x = XA; m_up = 1'b0; end
        else m_x = m_x + STEP;
      end else begin
        if (m_x <= STEP) begin m_x = 0; m_up = 1'b1; end
        else m_x = m_x - STEP;
      end
    end
  endtask

  function automatic logic btn_val(input int k);
    logic v = 1'b1;
    foreach (plans[i]) begin
      if (k >= plans[i].at && k < plans[i].at + plans[i].bounce)
        v = ((k - plans[i].at) % 2 == 1) ? 1'b0 : 1'b1;
      else if (k >= plans[i].at + plans[i].bounce &&
               k < plans[i].at + plans[i].bounce + plans[i].hold)
        v = 1'b0;
    end
    return v;
  endfunction

  // bounce is 0 or odd, so the steady low run starts exactly at at+bounce.
  task automatic add_press(input int at, input int bounce, input int hold);
    press_t p;
    p.at = at; p.bounce = bounce; p.hold = hold;
    plans.push_back(p);
    lands.push_back(at + bounce + LAT);
  endtask

  task automatic step(input logic vs);
    @(negedge clk);
    cyc++;
    exp_tick = (vs_d1 === 1'b0) && (vs_d2 === 1'b1);
    expv     = model_vec(exp_tick);
    obs      = {bus.frame_tick, bus.mode, bus.posterize_en, bus.split_en, bus.split_x};
    if (exp_tick) model_tick();
    bus.vsync = vs;
    cur_vs    = vs;
    bus.btn_n = btn_val(cyc);
    vs_d2     = vs_d1;
    vs_d1     = arst ? 1'b0 : vs;
  endtask

  task automatic do_reset_assert();
    arst = 1'b1;
    plans.delete();
    lands.delete();
    m_mode = 0; m_x = 0; m_up = 1'b1;
    vs_d1 = 1'b0; vs_d2 = 1'b0;
    bus.btn_n = 1'b1;
  endtask

  task automatic do_reset_release();
    arst  = 1'b0;
    vs_d1 = cur_vs;
  endtask

  task automatic test_reset();
    int ticks = 0;
    do_reset_assert();
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_cmp++;
      if (obs !== 16'h0000) begin n_bad++; $display("FAIL reset_state cyc=%0d actual=%h required=0000", cyc, obs); end
    end
    do_reset_release();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 60; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL idle_frames cyc=%0d actual=%h required=%h", cyc, obs, expv); end
        ticks += int'(obs[15]);
      end
    end
    n_cmp++;
    if (ticks != 3) begin n_bad++; $display("FAIL tick_count actual=%0d required=3", ticks); end
  endtask

  task automatic test_bounce_press();
    add_press(cyc + 1 + 10, 5, 20);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 60; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL bounce_press cyc=%0d actual=%h required=%h", cyc, obs, expv); end
        if (f == 1 && i == 1) begin
          n_cmp++;
          if (obs[14:13] !== 2'd0) begin n_bad++; $display("FAIL bounce_early_mode actual=%0d required=0", obs[14:13]); end
        end
        if (f == 1 && i == 2) begin
          n_cmp++;
          if (obs[14:0] !== {2'd1, 1'b1, 1'b1, 11'd32}) begin n_bad++; $display("FAIL split_outputs actual=%h required=%h", obs[14:0], {2'd1, 1'b1, 1'b1, 11'd32}); end
        end
      end
    end
  endtask

  task automatic test_multi_press();
    int f0 = cyc + 1;
    add_press(f0 + 5, 0, 20);
    add_press(f0 + 50, 0, 20);
    add_press(f0 + 95, 0, 20);
    for (int i = 0; i < 150; i++) begin
      step(i < 4 ? 1'b0 : 1'b1);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("FAIL multi_press cyc=%0d actual=%h required=%h", cyc, obs, expv); end
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 60; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL multi_after cyc=%0d actual=%h required=%h", cyc, obs, expv); end
        if (i == 59) begin
          n_cmp++;
          if (obs[14:13] !== 2'd2) begin n_bad++; $display("FAIL single_advance actual=%0d required=2", obs[14:13]); end
        end
      end
    end
  endtask

  task automatic test_sweep();
    int tab[8] = '{0, 24, 48, 64, 40, 16, 0, 24};
    add_press(cyc + 1 + 10, 0, 20);
    for (int i = 0; i < 60; i++) begin
      step(i < 4 ? 1'b0 : 1'b1);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("FAIL sweep_enter cyc=%0d actual=%h required=%h", cyc, obs, expv); end
    end
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 60; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL sweep_frame cyc=%0d actual=%h required=%h", cyc, obs, expv); end
        if (i == 2) begin
          n_cmp++;
          if (obs[14:0] !== {2'd3, 1'b1, 1'b1, XW'(tab[f])}) begin n_bad++; $display("FAIL sweep_x frame=%0d actual=%0d required=%0d", f, obs[10:0], tab[f]); end
        end
      end
    end
  endtask

  task automatic test_wrap_coincident();
    add_press(cyc + 1 + 10, 0, 20);
    for (int f = 0; f < 4; f++) begin
      if (f == 1) add_press(cyc + 1 + 60 + 1 - LAT, 0, 20);
      for (int i = 0; i < 60; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL wrap_coinc cyc=%0d actual=%h required=%h", cyc, obs, expv); end
        if (f == 1 && i == 2) begin
          n_cmp++;
          if (obs[14:0] !== 15'h0000) begin n_bad++; $display("FAIL wrap_bypass actual=%h required=0000", obs[14:0]); end
        end
        if (f == 2 && i == 1) begin
          n_cmp++;
          if (obs[15:13] !== 3'b100) begin n_bad++; $display("FAIL coinc_tick actual=%b required=100", obs[15:13]); end
        end
        if (f == 2 && i == 2) begin
          n_cmp++;
          if (obs[14:13] !== 2'd1) begin n_bad++; $display("FAIL coinc_advance actual=%0d required=1", obs[14:13]); end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 14; f++) begin
      int len = int'($urandom_range(70, 90));
      if ($urandom_range(0, 1) == 1)
        add_press(cyc + 1 + int'($urandom_range(5, 15)), 2 * int'($urandom_range(0, 3)) + 1, int'($urandom_range(20, 25)));
      for (int i = 0; i < len; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL random_frame cyc=%0d actual=%h required=%h", cyc, obs, expv); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 60; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        if (i == 2 && m_mode != 3) add_press(cyc + 8, 1, 20);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL to_sweep cyc=%0d actual=%h required=%h", cyc, obs, expv); end
      end
    end
    n_cmp++;
    if (obs[14:13] !== 2'd3) begin n_bad++; $display("FAIL in_sweep actual=%0d required=3", obs[14:13]); end
    add_press(cyc + 1 + 10, 0, 20);
    for (int i = 0; i < 20; i++) begin
      step(i < 4 ? 1'b0 : 1'b1);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("FAIL pre_reset cyc=%0d actual=%h required=%h", cyc, obs, expv); end
    end
    do_reset_assert();
    #1;
    n_cmp++;
    if ({bus.frame_tick, bus.mode, bus.posterize_en, bus.split_en, bus.split_x} !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_reset actual=%h required=0000", {bus.frame_tick, bus.mode, bus.posterize_en, bus.split_en, bus.split_x});
    end
    bus.vsync = 1'b0;
    cur_vs    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      n_cmp++;
      if (obs !== 16'h0000) begin n_bad++; $display("FAIL reset_hold cyc=%0d actual=%h required=0000", cyc, obs); end
    end
    do_reset_release();
    for (int i = 0; i < 30; i++) begin
      step(i < 10 ? 1'b0 : 1'b1);
      n_cmp++;
      if (obs !== 16'h0000) begin n_bad++; $display("FAIL no_spurious_tick cyc=%0d actual=%h required=0000", cyc, obs); end
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 60; i++) begin
        step(i < 4 ? 1'b0 : 1'b1);
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL post_reset cyc=%0d actual=%h required=%h", cyc, obs, expv); end
        if (i == 1) begin
          n_cmp++;
          if (obs[15:13] !== 3'b100) begin n_bad++; $display("FAIL post_reset_tick actual=%b required=100", obs[15:13]); end
        end
      end
    end
  endtask

  initial begin
    bus.btn_n = 1'b1;
    bus.vsync = 1'b1;
    cur_vs    = 1'b1;
    test_reset();
    test_bounce_press();
    test_multi_press();
    test_sweep();
    test_wrap_coincident();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end
endmodule
